// File: rtl/alu_sequencer.sv
// Sequences one ALU opcode at a time: accept, operand fetch, one-cycle execute, write-back.
// Register op retires 3 cycles after accept. Src and Wb handshakes hold the FSM; i_Enable low freezes it.
module alu_sequencer (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Enable,
  input  logic       i_Op_Valid,
  output logic       o_Op_Ready,
  input  logic [7:0] i_Opcode,
  input  logic       i_CB,
  output logic       o_Src_Req,
  output logic [2:0] o_Src_Sel,
  output logic       o_Src_Imm,
  input  logic       i_Src_Valid,
  input  logic [7:0] i_Src_Data,
  output logic [7:0] o_ALU_Opcode,
  output logic [7:0] o_Parameter,
  output logic [5:0] o_Function_Control,
  output logic       o_Save_Flags,
  input  logic [7:0] i_Result,
  output logic [1:0] o_Write,
  output logic [7:0] o_Data,
  output logic       o_Wb_Valid,
  input  logic       i_Wb_Ready,
  output logic [2:0] o_Wb_Sel,
  output logic [7:0] o_Wb_Data,
  output logic       o_Done,
  output logic       o_Illegal
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WB} state_t;

  localparam logic [2:0] DEST_A = 3'd7;

  state_t     r_state;
  logic [7:0] r_opcode;
  logic [5:0] r_fc;
  logic [2:0] r_src_sel;
  logic       r_src_imm;
  logic       r_has_wb;
  logic [2:0] r_dest;
  logic [7:0] r_param;
  logic [7:0] r_result;
  logic       r_illegal;

  logic       w_legal;
  logic       w_imm;
  logic       w_fetch;
  logic       w_has_wb;
  logic [5:0] w_fc;
  logic [2:0] w_src;
  logic [2:0] w_dest;

  // Opcode decode; unit bits follow the ALU map (0 main, 1 inc, 2 dec, 3 logic, 4 no-Z, 5 misc)
  always_comb begin
    w_legal  = 1'b1;
    w_imm    = 1'b0;
    w_fetch  = 1'b1;
    w_has_wb = 1'b1;
    w_fc     = 6'b000000;
    w_src    = i_Opcode[2:0];
    w_dest   = DEST_A;
    if (i_CB) begin
      w_fc = 6'b001000;
      if (i_Opcode[7:6] == 2'b01) w_has_wb = 1'b0;
      else                        w_dest   = i_Opcode[2:0];
    end else begin
      casez (i_Opcode)
        8'b10??????: begin
          w_fc     = 6'b000001;
          w_has_wb = (i_Opcode[5:3] != 3'd7);
        end
        8'b11???110: begin
          w_fc     = 6'b000001;
          w_imm    = 1'b1;
          w_has_wb = (i_Opcode[5:3] != 3'd7);
        end
        8'b00???100: begin
          w_fc   = 6'b000010;
          w_src  = i_Opcode[5:3];
          w_dest = i_Opcode[5:3];
        end
        8'b00???101: begin
          w_fc   = 6'b000110;
          w_src  = i_Opcode[5:3];
          w_dest = i_Opcode[5:3];
        end
        8'b000??111: begin
          w_fc  = 6'b011000;
          w_src = DEST_A;
        end
        8'b001??111: begin
          w_fc    = 6'b100000;
          w_fetch = 1'b0;
        end
        default: w_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state   <= S_IDLE;
      r_opcode  <= 8'd0;
      r_fc      <= 6'd0;
      r_src_sel <= 3'd0;
      r_src_imm <= 1'b0;
      r_has_wb  <= 1'b0;
      r_dest    <= 3'd0;
      r_param   <= 8'd0;
      r_result  <= 8'd0;
      r_illegal <= 1'b0;
    end else if (i_Enable) begin
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_Op_Valid) begin
            r_opcode  <= i_Opcode;
            r_fc      <= w_fc;
            r_src_sel <= w_src;
            r_src_imm <= w_imm;
            r_has_wb  <= w_has_wb;
            r_dest    <= w_dest;
            if (!w_legal)     r_illegal <= 1'b1;
            else if (w_fetch) r_state   <= S_FETCH;
            else              r_state   <= S_EXEC;
          end
        end
        S_FETCH: begin
          if (i_Src_Valid) begin
            r_param <= i_Src_Data;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= i_Result;
          r_state  <= r_has_wb ? S_WB : S_IDLE;
        end
        S_WB: begin
          if (r_dest == DEST_A || i_Wb_Ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  logic w_run;
  logic w_strobe;
  logic w_exec;
  logic w_wb_a;
  logic w_wb_reg;

  // Outputs read zero during reset; strobes additionally vanish while disabled
  assign w_run    = ~i_Reset;
  assign w_strobe = ~i_Reset & i_Enable;
  assign w_exec   = (r_state == S_EXEC);
  assign w_wb_a   = (r_state == S_WB) && (r_dest == DEST_A);
  assign w_wb_reg = (r_state == S_WB) && (r_dest != DEST_A);

  assign o_Op_Ready         = w_run & (r_state == S_IDLE);
  assign o_Src_Req          = w_run & (r_state == S_FETCH);
  assign o_Src_Sel          = o_Src_Req ? r_src_sel : 3'd0;
  assign o_Src_Imm          = o_Src_Req & r_src_imm;
  assign o_ALU_Opcode       = w_run ? r_opcode : 8'd0;
  assign o_Parameter        = w_run ? r_param : 8'd0;
  assign o_Function_Control = (w_run & w_exec) ? r_fc : 6'd0;
  assign o_Save_Flags       = w_strobe & w_exec;
  assign o_Write            = {1'b0, w_strobe & w_wb_a};
  assign o_Data             = (w_run & w_wb_a) ? r_result : 8'd0;
  assign o_Wb_Valid         = w_run & w_wb_reg;
  assign o_Wb_Sel           = o_Wb_Valid ? r_dest : 3'd0;
  assign o_Wb_Data          = o_Wb_Valid ? r_result : 8'd0;
  assign o_Done             = w_strobe & ((w_exec & ~r_has_wb) | w_wb_a | (w_wb_reg & i_Wb_Ready));
  assign o_Illegal          = w_strobe & r_illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed test-plan cases plus random opcodes against a decode-table model.
module tb_alu_sequencer;
  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Enable = 1'b1;
  logic       i_Op_Valid = 1'b0;
  logic       o_Op_Ready;
  logic [7:0] i_Opcode = 8'd0;
  logic       i_CB = 1'b0;
  logic       o_Src_Req;
  logic [2:0] o_Src_Sel;
  logic       o_Src_Imm;
  logic       i_Src_Valid = 1'b0;
  logic [7:0] i_Src_Data = 8'd0;
  logic [7:0] o_ALU_Opcode;
  logic [7:0] o_Parameter;
  logic [5:0] o_Function_Control;
  logic       o_Save_Flags;
  logic [7:0] i_Result = 8'd0;
  logic [1:0] o_Write;
  logic [7:0] o_Data;
  logic       o_Wb_Valid;
  logic       i_Wb_Ready = 1'b0;
  logic [2:0] o_Wb_Sel;
  logic [7:0] o_Wb_Data;
  logic       o_Done;
  logic       o_Illegal;

  always #5 i_Clk = ~i_Clk;

  alu_sequencer dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Enable(i_Enable),
    .i_Op_Valid(i_Op_Valid), .o_Op_Ready(o_Op_Ready), .i_Opcode(i_Opcode), .i_CB(i_CB),
    .o_Src_Req(o_Src_Req), .o_Src_Sel(o_Src_Sel), .o_Src_Imm(o_Src_Imm),
    .i_Src_Valid(i_Src_Valid), .i_Src_Data(i_Src_Data),
    .o_ALU_Opcode(o_ALU_Opcode), .o_Parameter(o_Parameter),
    .o_Function_Control(o_Function_Control), .o_Save_Flags(o_Save_Flags),
    .i_Result(i_Result), .o_Write(o_Write), .o_Data(o_Data),
    .o_Wb_Valid(o_Wb_Valid), .i_Wb_Ready(i_Wb_Ready), .o_Wb_Sel(o_Wb_Sel), .o_Wb_Data(o_Wb_Data),
    .o_Done(o_Done), .o_Illegal(o_Illegal)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {o_Op_Ready, o_Src_Req, o_Src_Sel, o_Src_Imm, o_ALU_Opcode, o_Parameter,
            o_Function_Control, o_Save_Flags, o_Write, o_Data, o_Wb_Valid, o_Wb_Sel,
            o_Wb_Data, o_Done, o_Illegal};
  endfunction

  function automatic logic [15:0] strobes();
    return {o_Save_Flags, o_Write, o_Done, o_Illegal, o_Function_Control, o_Src_Req, o_Wb_Valid};
  endfunction

  // Reference decode written straight from the opcode table
  function automatic void model(input int op, input bit cb, output bit legal, output int fc,
                                output int src, output bit imm, output bit fetch,
                                output bit wb, output int dest);
    int hi, mid, lo;
    hi = op / 64; mid = (op / 8) % 8; lo = op % 8;
    legal = 1; fc = 0; src = 0; imm = 0; fetch = 1; wb = 1; dest = 7;
    if (cb) begin
      fc = 8; src = lo;
      if (hi == 1) wb = 0; else dest = lo;
    end else if (hi == 2) begin
      fc = 1; src = lo; wb = (mid != 7);
    end else if (hi == 3 && lo == 6) begin
      fc = 1; imm = 1; wb = (mid != 7);
    end else if (hi == 0 && lo == 4) begin
      fc = 2; src = mid; dest = mid;
    end else if (hi == 0 && lo == 5) begin
      fc = 6; src = mid; dest = mid;
    end else if (op == 'h07 || op == 'h0F || op == 'h17 || op == 'h1F) begin
      fc = 24; src = 7;
    end else if (op == 'h27 || op == 'h2F || op == 'h37 || op == 'h3F) begin
      fc = 32; fetch = 0;
    end else begin
      legal = 0;
    end
  endfunction

  // One full instruction; sw/ww are wait cycles before Src_Valid / Wb_Ready
  task automatic do_op(input logic [7:0] op, input bit cb, input logic [7:0] sd,
                       input logic [7:0] res, input int sw, input int ww);
    bit legal, imm, fetch, wb;
    int fc, src, dest;
    model(int'(op), cb, legal, fc, src, imm, fetch, wb, dest);
    @(negedge i_Clk);
    i_Op_Valid = 1'b1; i_Opcode = op; i_CB = cb; i_Src_Data = sd; i_Result = res;
    i_Src_Valid = 1'b0; i_Wb_Ready = 1'b0;
    #1;
    chk("accept_ready", o_Op_Ready, 1);
    @(negedge i_Clk);
    i_Op_Valid = 1'b0;
    #1;
    if (!legal) begin
      chk("illegal_pulse", o_Illegal, 1);
      chk("illegal_quiet", {o_Save_Flags, o_Write, o_Done, o_Function_Control, o_Src_Req, o_Wb_Valid}, 0);
      chk("illegal_ready", o_Op_Ready, 1);
      @(negedge i_Clk); #1;
      chk("illegal_once", o_Illegal, 0);
      return;
    end
    if (fetch) begin
      for (int i = 0; i <= sw; i++) begin
        if (i == sw) i_Src_Valid = 1'b1;
        chk("fetch_req", o_Src_Req, 1);
        chk("fetch_imm", o_Src_Imm, imm);
        if (!imm) chk("fetch_sel", o_Src_Sel, src);
        chk("fetch_quiet", {o_Save_Flags, o_Write, o_Done, o_Function_Control, o_Op_Ready}, 0);
        @(negedge i_Clk); #1;
      end
      i_Src_Valid = 1'b0;
      i_Src_Data  = ~sd;
    end
    chk("exec_fc", o_Function_Control, fc);
    chk("exec_save", o_Save_Flags, 1);
    chk("exec_opcode", o_ALU_Opcode, op);
    if (fetch) chk("exec_param", o_Parameter, sd);
    chk("exec_src_req", o_Src_Req, 0);
    chk("exec_done", o_Done, !wb);
    chk("exec_write", {o_Write, o_Wb_Valid}, 0);
    if (wb) begin
      @(negedge i_Clk);
      i_Result = ~res;
      #1;
      if (dest == 7) begin
        chk("wb_a_write", o_Write, 2'b01);
        chk("wb_a_data", o_Data, res);
        chk("wb_a_done", o_Done, 1);
        chk("wb_a_quiet", {o_Wb_Valid, o_Save_Flags, o_Function_Control}, 0);
      end else begin
        for (int i = 0; i <= ww; i++) begin
          if (i == ww) begin i_Wb_Ready = 1'b1; #1; end
          chk("wb_valid", o_Wb_Valid, 1);
          chk("wb_sel", o_Wb_Sel, dest);
          chk("wb_data", o_Wb_Data, res);
          chk("wb_done", o_Done, i == ww);
          chk("wb_write", o_Write, 0);
          if (i < ww) begin @(negedge i_Clk); #1; end
        end
      end
    end
    @(negedge i_Clk);
    i_Wb_Ready = 1'b0;
    #1;
    chk("retire_ready", o_Op_Ready, 1);
    chk("retire_quiet", strobes(), 0);
  endtask

  initial begin
    @(negedge i_Clk); @(negedge i_Clk); #1;
    chk("reset_outputs", all_outs(), 0);
    i_Reset = 1'b0; #1;
    chk("reset_release_ready", o_Op_Ready, 1);

    do_op(8'h80, 1'b0, 8'h3A, 8'h7F, 0, 0);   // ADD A,B
    do_op(8'hFE, 1'b0, 8'h10, 8'h55, 0, 0);   // CP d8
    do_op(8'h35, 1'b0, 8'h42, 8'h41, 0, 3);   // DEC (HL)
    do_op(8'h2F, 1'b0, 8'h00, 8'hC3, 0, 0);   // CPL
    do_op(8'h11, 1'b1, 8'h81, 8'h02, 0, 0);   // RL C
    do_op(8'hD3, 1'b0, 8'h00, 8'h00, 0, 0);   // illegal
    do_op(8'h46, 1'b1, 8'h0F, 8'h00, 1, 0);   // BIT 0,(HL)
    do_op(8'h3C, 1'b0, 8'h09, 8'h0A, 2, 0);   // INC A

    // Enable low during EXEC holds state and suppresses strobes
    @(negedge i_Clk);
    i_Op_Valid = 1'b1; i_Opcode = 8'h81; i_CB = 1'b0; i_Src_Data = 8'h11; i_Result = 8'h22;
    @(negedge i_Clk);
    i_Op_Valid = 1'b0; i_Src_Valid = 1'b1;
    @(negedge i_Clk);
    i_Src_Valid = 1'b0; i_Enable = 1'b0; #1;
    chk("en_low_save", o_Save_Flags, 0);
    @(negedge i_Clk); #1;
    chk("en_low_hold_fc", o_Function_Control, 6'b000001);
    chk("en_low_quiet", {o_Save_Flags, o_Write, o_Done}, 0);
    i_Enable = 1'b1; #1;
    chk("en_high_save", o_Save_Flags, 1);
    @(negedge i_Clk); #1;
    chk("en_wb_write", o_Write, 2'b01);
    chk("en_wb_data", o_Data, 8'h22);
    @(negedge i_Clk); #1;
    chk("en_retire_ready", o_Op_Ready, 1);

    // Reset mid-FETCH, then a late Src_Valid must be ignored
    @(negedge i_Clk);
    i_Op_Valid = 1'b1; i_Opcode = 8'h80; i_CB = 1'b0;
    @(negedge i_Clk);
    i_Op_Valid = 1'b0; #1;
    chk("rst_pre_req", o_Src_Req, 1);
    i_Reset = 1'b1; #1;
    chk("rst_mid_outputs", all_outs(), 0);
    @(negedge i_Clk); #1;
    chk("rst_held_outputs", all_outs(), 0);
    i_Reset = 1'b0; i_Src_Valid = 1'b1; i_Wb_Ready = 1'b1; #1;
    chk("rst_after_ready", o_Op_Ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_Clk); #1;
      chk("rst_late_quiet", strobes(), 0);
      chk("rst_late_ready", o_Op_Ready, 1);
    end
    i_Src_Valid = 1'b0; i_Wb_Ready = 1'b0;

    for (int n = 0; n < 80; n++) begin
      do_op(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8'($urandom),
            8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
